ysyx_24100006_ifu: RTL and testbench
====================================

YSYX_24100006_IFU -- requirements
Module: ysyx_24100006_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h3000_0000, the fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-004 SHALL have port redirect_valid, input, 1 bit, flush request from a downstream stage.
REQ-005 SHALL have port redirect_pc, input, 32 bits, the new fetch target; qualified by redirect_valid.
REQ-006 SHALL have port imem_req_valid, output, 1 bit, instruction-memory request valid.
REQ-007 SHALL have port imem_req_ready, input, 1 bit, memory accepts the request.
REQ-008 SHALL have port imem_req_addr, output, 32 bits, request address (always equal to pc_q).
REQ-009 SHALL have port imem_resp_valid, input, 1 bit, read data valid.
REQ-010 SHALL have port imem_resp_data, input, 32 bits, fetched instruction.
REQ-011 SHALL have port out_valid, output, 1 bit, instruction available to the IF/ID register.
REQ-012 SHALL have port out_ready, input, 1 bit, the IF/ID register can accept.
REQ-013 SHALL have port instruction_o, output, 32 bits, held instruction.
REQ-014 SHALL have port pc_o, output, 32 bits, PC of the held instruction.
REQ-015 SHALL have port pc_add_4_o, output, 32 bits, pc_o+4, modulo 2^32.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, HOLD; at most one memory transaction outstanding.
REQ-017 SHALL assert imem_req_valid only when (state==REQ && !redirect_valid); address is stable while imem_req_valid is high.
REQ-018 SHALL make the following transitions: IDLE->REQ unconditionally; REQ->WAIT on req handshake; WAIT->HOLD on imem_resp_valid with drop_q==0; WAIT->REQ on imem_resp_valid with drop_q==1; HOLD->REQ on out_ready.
REQ-019 SHALL capture imem_resp_data into instruction_q on the WAIT->HOLD transition; out_valid = (state==HOLD), registered, with no combinational path from imem_resp_* to out_*.
REQ-020 SHALL give a minimum latency of 2 cycles from the req handshake edge to out_valid=1 for a zero-wait memory (handshake cycle N, response cycle N+1, out_valid at N+2).
REQ-021 SHALL, in HOLD, keep out_valid, instruction_o, pc_o and pc_add_4_o stable until out_ready; on out_ready, pc_q <= pc_q+4 (wraps 32'hFFFF_FFFC->0).
REQ-022 SHALL treat redirect_valid as highest priority in every state: pc_q <= redirect_pc.
REQ-023 SHALL handle a redirect by state: in REQ, stay in REQ (no handshake occurs that cycle); in HOLD, go to REQ, drop the held instruction, ignore out_ready; in IDLE, go to REQ.
REQ-024 SHALL handle a redirect in WAIT as follows: without imem_resp_valid, set drop_q and stay in WAIT; with simultaneous imem_resp_valid, discard the data, clear drop_q and go to REQ.
REQ-025 SHALL clear drop_q when a dropped response arrives; the discarded data never reaches instruction_q.
REQ-026 SHALL ignore imem_resp_valid outside WAIT.
REQ-027 SHALL treat a back-to-back redirect while drop_q=1 as follows: the latest redirect_pc wins, and one response is still discarded.

Reset
REQ-028 SHALL, on reset, set state=IDLE, pc_q=RESET_PC, drop_q=0, out_valid=0 and imem_req_valid=0; instruction_q is not reset.
REQ-029 SHALL abandon any outstanding transaction when reset is asserted mid-operation; memory is reset by the same reset.

Verification
REQ-030 SHALL pass this scenario: reset released, zero-wait memory, out_ready=1 -> first imem_req_addr=32'h3000_0000, then 32'h3000_0004 and 32'h3000_0008, with pc_add_4_o=pc_o+4.
REQ-031 SHALL pass this scenario: out_ready=0 for 5 cycles in HOLD -> out_valid, instruction_o and pc_o are constant, and no new imem request is made.
REQ-032 SHALL pass this scenario: redirect_pc=32'h8000_0010 while in WAIT, response delayed 3 cycles -> the response is discarded, the next request address is 32'h8000_0010, and out_valid stays 0 until that response arrives.
REQ-033 SHALL pass this scenario: redirect in the same cycle as imem_resp_valid -> no out_valid pulse, and the next request goes to redirect_pc.
REQ-034 SHALL pass this scenario: redirect in HOLD with out_ready=1 -> pc_q becomes redirect_pc (not pc+4), and out_valid=0 the next cycle.
REQ-035 SHALL pass this scenario: pc_q=32'hFFFF_FFFC accepted -> pc_add_4_o=0, and the next request address is 0.

Source files
------------

// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch unit.
// Fetches one instruction at a time from instruction memory and holds it
// until the IF/ID register accepts it. At most one memory transaction is
// outstanding. A redirect from a downstream stage overrides everything and
// retargets the fetch PC.
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   redirect_valid, redirect_pc      - flush request and new fetch target
//   imem_req_valid/ready/addr        - memory request channel (addr == pc_q)
//   imem_resp_valid/data             - memory response channel
//   out_valid, out_ready             - handshake towards the IF/ID register
//   instruction_o, pc_o, pc_add_4_o  - held instruction, its PC and PC+4
module ysyx_24100006_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_add_4_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Set when the outstanding response belongs to a flushed fetch.
    logic        drop_q, drop_d;
    logic [31:0] instruction_q;
    logic        capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Data register is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            instruction_q <= imem_resp_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        capture = 1'b0;

        if (redirect_valid) begin
            pc_d = redirect_pc;
            case (state_q)
                StWait: begin
                    if (imem_resp_valid) begin
                        // Response arriving alongside the redirect is stale.
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = StReq;
            endcase
        end else begin
            case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imem_req_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            state_d = StReq;
                            drop_d  = 1'b0;
                        end else begin
                            state_d = StHold;
                            capture = !reset;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_d = StReq;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A redirect in REQ suppresses the request so the address never changes
    // under an asserted valid.
    assign imem_req_valid = (state_q == StReq) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign out_valid      = (state_q == StHold);
    assign instruction_o  = instruction_q;
    assign pc_o           = pc_q;
    assign pc_add_4_o     = pc_q + 32'd4;

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
module tb_ysyx_24100006_ifu;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic [31:0] pc_add_4_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          mem_lat;  // -1 selects a random latency 0..3

    ysyx_24100006_ifu #(
        .RESET_PC(32'h3000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction_o  (instruction_o),
        .pc_o           (pc_o),
        .pc_add_4_o     (pc_add_4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: memory sees this cycle's handshake, redirect is a one-cycle pulse.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (imem_resp_valid) mem_pend = 1'b0;
        if (hs) begin
            mem_pend  = 1'b1;
            mem_addr  = a;
            mem_delay = (mem_lat < 0) ? int'($urandom_range(3)) : mem_lat;
        end else if (mem_pend && mem_delay > 0) begin
            mem_delay--;
        end
        imem_resp_valid = mem_pend && (mem_delay == 0);
        imem_resp_data  = imem_resp_valid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        out_ready       = 1'b0;
        mem_pend        = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        reset = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_add4;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[5];

    // Transaction-level reference model flags
    logic        m_idle, m_busy, m_hold, m_stale, req_phase, resp;
    logic [31:0] m_pc;

    initial begin
        vecs[0] = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0004};
        vecs[1] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0014};
        vecs[3] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
        vecs[4] = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0000};
        mem_lat = 0;

        // Sequential fetch with zero-wait memory
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        chk("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("seq_req_addr", imem_req_addr, 32'h3000_0000 + 32'(k * 4));
            tick();
            chk("seq_wait_no_out", {31'b0, out_valid}, 32'd0);
            tick();
            chk("seq_out_valid", {31'b0, out_valid}, 32'd1);
            chk("seq_pc", pc_o, 32'h3000_0000 + 32'(k * 4));
            chk("seq_pc4", pc_add_4_o, 32'h3000_0004 + 32'(k * 4));
            chk("seq_instr", instruction_o, mem_word(32'h3000_0000 + 32'(k * 4)));
        end

        // Stall in HOLD for 5 cycles
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_pc", pc_o, 32'h3000_0000);
            chk("stall_instr", instruction_o, mem_word(32'h3000_0000));
            chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("stall_release_addr", imem_req_addr, 32'h3000_0004);
        chk("stall_release_req", {31'b0, imem_req_valid}, 32'd1);

        // Redirect in WAIT with a delayed response
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        mem_lat        = 3;
        tick();
        chk("wr_first_addr", imem_req_addr, 32'h3000_0000);
        tick();
        chk("wr_resp_pending", {31'b0, imem_resp_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0010;
        #1;
        chk("wr_req_in_wait", {31'b0, imem_req_valid}, 32'd0);
        tick();
        mem_lat = 0;
        for (int k = 0; k < 10; k++) begin
            if (imem_resp_valid) break;
            chk("wr_no_out", {31'b0, out_valid}, 32'd0);
            chk("wr_no_req", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        chk("wr_resp_arrived", {31'b0, imem_resp_valid}, 32'd1);
        tick();
        chk("wr_dropped_no_out", {31'b0, out_valid}, 32'd0);
        chk("wr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wr_req_addr", imem_req_addr, 32'h8000_0010);
        tick();
        tick();
        chk("wr_out_valid", {31'b0, out_valid}, 32'd1);
        chk("wr_pc", pc_o, 32'h8000_0010);
        chk("wr_instr", instruction_o, mem_word(32'h8000_0010));

        // Redirect in the same cycle as the response
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        mem_lat        = 2;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            if (imem_resp_valid) break;
            tick();
        end
        chk("sr_resp_arrived", {31'b0, imem_resp_valid}, 32'd1);
        mem_lat        = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        tick();
        chk("sr_no_out", {31'b0, out_valid}, 32'd0);
        chk("sr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("sr_req_addr", imem_req_addr, 32'h0000_1000);
        tick();
        chk("sr_wait_no_out", {31'b0, out_valid}, 32'd0);
        tick();
        chk("sr_pc", pc_o, 32'h0000_1000);

        // Redirect in HOLD with out_ready high
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        tick();
        tick();
        tick();
        chk("rh_out_valid", {31'b0, out_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0020;
        tick();
        chk("rh_no_out", {31'b0, out_valid}, 32'd0);
        chk("rh_req_addr", imem_req_addr, 32'h4000_0020);
        chk("rh_pc", pc_o, 32'h4000_0020);

        // Table: redirect from IDLE to a target, fetch, check PC+4 and next address
        for (int v = 0; v < 5; v++) begin
            do_reset();
            imem_req_ready = 1'b1;
            out_ready      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].target;
            #1;
            chk("tv_idle_no_req", {31'b0, imem_req_valid}, 32'd0);
            tick();
            chk("tv_req_addr", imem_req_addr, vecs[v].target);
            tick();
            tick();
            chk("tv_pc", pc_o, vecs[v].target);
            chk("tv_pc4", pc_add_4_o, vecs[v].exp_add4);
            chk("tv_instr", instruction_o, mem_word(vecs[v].target));
            tick();
            chk("tv_next_addr", imem_req_addr, vecs[v].exp_next);
        end

        // Randomized run against the reference model
        do_reset();
        mem_lat = -1;
        m_idle  = 1'b1;
        m_busy  = 1'b0;
        m_hold  = 1'b0;
        m_stale = 1'b0;
        m_pc    = 32'h3000_0000;
        for (int c = 0; c < 3000; c++) begin
            redirect_valid = ($urandom_range(9) == 0);
            redirect_pc    = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'd3);
            imem_req_ready = ($urandom_range(2) != 0);
            out_ready      = ($urandom_range(1) != 0);
            #1;
            req_phase = !m_idle && !m_busy && !m_hold;
            resp      = imem_resp_valid;
            chk("rnd_req_valid", {31'b0, imem_req_valid}, {31'b0, req_phase && !redirect_valid});
            if (req_phase) chk("rnd_req_addr", imem_req_addr, m_pc);
            chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, m_hold});
            if (m_hold) begin
                chk("rnd_pc", pc_o, m_pc);
                chk("rnd_pc4", pc_add_4_o, m_pc + 32'd4);
                chk("rnd_instr", instruction_o, mem_word(m_pc));
            end
            if (redirect_valid) begin
                m_pc   = redirect_pc;
                m_idle = 1'b0;
                m_hold = 1'b0;
                if (m_busy) begin
                    if (resp) begin
                        m_busy  = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (req_phase) begin
                if (imem_req_ready) m_busy = 1'b1;
            end else if (m_busy) begin
                if (resp) begin
                    m_busy = 1'b0;
                    if (m_stale) m_stale = 1'b0;
                    else m_hold = 1'b1;
                end
            end else if (m_hold && out_ready) begin
                m_hold = 1'b0;
                m_pc   = m_pc + 32'd4;
            end
            tick();
        end

        // Reset in the middle of operation restarts from the reset PC
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        chk("post_reset_addr", imem_req_addr, 32'h3000_0000);
        chk("post_reset_req", {31'b0, imem_req_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
